// File: rtl/llr_stream_checker.sv
// Self-check block for the APSK LLR demapper: queues golden LLR vectors and compares
// each one against the next valid demapper output, with per-mode statistics.
module llr_stream_checker #(
    parameter int LLR_W = 19,
    parameter int LANES = 6,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             Mode,
    input  logic                   exp_valid,
    input  logic [LANES*LLR_W-1:0] exp_llr,
    input  logic                   dut_valid,
    input  logic [LANES*LLR_W-1:0] dut_llr,
    input  logic                   clr,
    input  logic [2:0]             rd_mode,
    output logic [CNT_W-1:0]       rd_test_cnt,
    output logic [CNT_W-1:0]       rd_pass_cnt,
    output logic                   match,
    output logic                   mismatch,
    output logic                   first_err_valid,
    output logic [2:0]             first_err_mode,
    output logic [CNT_W-1:0]       first_err_idx,
    output logic [LANES-1:0]       first_err_lanes,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   mode_err,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = LANES * LLR_W;
    localparam int EW = DW + 3;
    localparam logic [AW:0]      DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           r_state, w_state_next;
    logic [2:0]       r_run_mode, w_run_mode_next;
    logic [2:0]       w_mode;
    logic             w_flush, w_mode_err_evt;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]      w_count, w_count_after;
    logic             w_empty, w_full;
    logic             w_pop_state, w_push_req, w_push, w_pop, w_ovf_evt, w_unf_evt;
    logic [EW-1:0]    w_head;
    logic [2:0]       w_head_mode;
    logic [LANES-1:0] w_lane_diff;

    logic             r_cmp_valid;
    logic [2:0]       r_cmp_mode;
    logic [LANES-1:0] r_cmp_diff;
    logic             w_cmp_pass;

    logic [CNT_W-1:0] r_test_cnt [8];
    logic [CNT_W-1:0] r_pass_cnt [8];

    logic [CNT_W-1:0] r_rd_test, r_rd_pass;
    logic             r_match, r_mismatch;
    logic             r_err_valid;
    logic [2:0]       r_err_mode;
    logic [CNT_W-1:0] r_err_idx;
    logic [LANES-1:0] r_err_lanes;
    logic             r_overflow, r_underflow, r_mode_err;

    // Modes 6/7 behave exactly like idle
    assign w_mode = (Mode >= 3'd1 && Mode <= 3'd5) ? Mode : 3'd0;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == DEPTH_C);
    assign w_pop_state = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_push_req  = (r_state == S_RUN) && exp_valid && (w_mode != 3'd0) && !w_flush;
    assign w_pop       = w_pop_state && dut_valid && !w_empty && !w_flush;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt   = w_push_req && w_full && !w_pop;
    assign w_unf_evt   = w_pop_state && dut_valid && w_empty && !w_flush;
    assign w_count_after = w_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    always_comb begin
        w_state_next    = r_state;
        w_run_mode_next = r_run_mode;
        w_flush         = 1'b0;
        w_mode_err_evt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mode != 3'd0) begin
                    w_state_next    = S_RUN;
                    w_run_mode_next = w_mode;
                end
            end
            S_RUN: begin
                if (w_mode == 3'd0) begin
                    w_state_next = (w_count_after != '0) ? S_DRAIN : S_IDLE;
                end else if (w_mode != r_run_mode) begin
                    // Vectors queued under the old mode can no longer be aligned
                    w_flush         = 1'b1;
                    w_mode_err_evt  = 1'b1;
                    w_run_mode_next = w_mode;
                end
            end
            S_DRAIN: begin
                if (w_count_after == '0) begin
                    if (w_mode != 3'd0) begin
                        w_state_next    = S_RUN;
                        w_run_mode_next = w_mode;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_run_mode <= 3'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_run_mode <= w_run_mode_next;
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_mode, exp_llr};
    end

    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_mode = w_head[EW-1 -: 3];

    // Lane 0 sits in the MSBs of both the LLR bus and the lane mask
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [2:0] LANE_IDX = 3'(gi);
        localparam int         LSB      = (LANES - 1 - gi) * LLR_W;
        assign w_lane_diff[LANES-1-gi] = (w_head_mode >= LANE_IDX) &&
                                         (w_head[LSB +: LLR_W] != dut_llr[LSB +: LLR_W]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_mode  <= 3'd0;
            r_cmp_diff  <= '0;
        end else begin
            r_cmp_valid <= w_pop;
            r_cmp_mode  <= w_head_mode;
            r_cmp_diff  <= w_lane_diff;
        end
    end

    assign w_cmp_pass = (r_cmp_diff == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int m = 0; m < 8; m++) begin
                r_test_cnt[m] <= '0;
                r_pass_cnt[m] <= '0;
            end
        end else if (r_cmp_valid) begin
            if (r_test_cnt[r_cmp_mode] != CNT_MAX)
                r_test_cnt[r_cmp_mode] <= r_test_cnt[r_cmp_mode] + 1'b1;
            if (w_cmp_pass && r_pass_cnt[r_cmp_mode] != CNT_MAX)
                r_pass_cnt[r_cmp_mode] <= r_pass_cnt[r_cmp_mode] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_test   <= '0;
            r_rd_pass   <= '0;
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_mode  <= 3'd0;
            r_err_idx   <= '0;
            r_err_lanes <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_mode_err  <= 1'b0;
        end else begin
            // Entries 0, 6 and 7 are never incremented, so those selects read 0
            r_rd_test  <= r_test_cnt[rd_mode];
            r_rd_pass  <= r_pass_cnt[rd_mode];
            r_match    <= r_cmp_valid && w_cmp_pass && !clr;
            r_mismatch <= r_cmp_valid && !w_cmp_pass && !clr;
            if (clr) begin
                r_err_valid <= 1'b0;
                r_err_mode  <= 3'd0;
                r_err_idx   <= '0;
                r_err_lanes <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
                r_mode_err  <= 1'b0;
            end else begin
                if (w_ovf_evt)      r_overflow  <= 1'b1;
                if (w_unf_evt)      r_underflow <= 1'b1;
                if (w_mode_err_evt) r_mode_err  <= 1'b1;
                if (r_cmp_valid && !w_cmp_pass && !r_err_valid) begin
                    r_err_valid <= 1'b1;
                    r_err_mode  <= r_cmp_mode;
                    r_err_idx   <= r_test_cnt[r_cmp_mode];
                    r_err_lanes <= r_cmp_diff;
                end
            end
        end
    end

    assign rd_test_cnt     = r_rd_test;
    assign rd_pass_cnt     = r_rd_pass;
    assign match           = r_match;
    assign mismatch        = r_mismatch;
    assign first_err_valid = r_err_valid;
    assign first_err_mode  = r_err_mode;
    assign first_err_idx   = r_err_idx;
    assign first_err_lanes = r_err_lanes;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;
    assign mode_err        = r_mode_err;
    assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_llr_stream_checker.sv
// Directed bench for llr_stream_checker: table of streaming scenarios plus hand-written
// sequences for overflow, drain, underflow/mode change, saturation and mid-run reset.
module tb_llr_stream_checker;

    localparam int LLR_W = 19;
    localparam int LANES = 6;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam int DW    = LANES * LLR_W;

    logic             clk, rst_n, exp_valid, dut_valid, clr;
    logic [2:0]       Mode, rd_mode;
    logic [DW-1:0]    exp_llr, dut_llr;
    logic [CNT_W-1:0] rd_test_cnt, rd_pass_cnt, first_err_idx;
    logic             match, mismatch, first_err_valid, overflow, underflow, mode_err, busy;
    logic [2:0]       first_err_mode;
    logic [LANES-1:0] first_err_lanes;

    llr_stream_checker #(.LLR_W(LLR_W), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .Mode(Mode), .exp_valid(exp_valid), .exp_llr(exp_llr),
        .dut_valid(dut_valid), .dut_llr(dut_llr), .clr(clr), .rd_mode(rd_mode),
        .rd_test_cnt(rd_test_cnt), .rd_pass_cnt(rd_pass_cnt), .match(match),
        .mismatch(mismatch), .first_err_valid(first_err_valid),
        .first_err_mode(first_err_mode), .first_err_idx(first_err_idx),
        .first_err_lanes(first_err_lanes), .overflow(overflow), .underflow(underflow),
        .mode_err(mode_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_match  = 0;
    int n_mism   = 0;

    always @(negedge clk) begin
        if (match)    n_match++;
        if (mismatch) n_mism++;
    end

    typedef struct {
        int mode; int nvec; int lat;
        int b1; int m1; int b2; int m2;
        int etest; int epass; int eerr; int eidx; int elanes;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] gold(input int idx);
        logic [DW-1:0] v;
        int unsigned   h;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            h = idx * 32'h9E3779B1 + l * 32'h85EBCA6B + 32'h1234;
            v[(LANES-1-l)*LLR_W +: LLR_W] = h[LLR_W-1:0] ^ h[31:32-LLR_W];
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] v, input int mask);
        logic [DW-1:0]    r;
        logic [LANES-1:0] mk;
        r  = v;
        mk = LANES'(mask);
        for (int l = 0; l < LANES; l++)
            if (mk[LANES-1-l]) r[(LANES-1-l)*LLR_W +: LLR_W] = ~v[(LANES-1-l)*LLR_W +: LLR_W];
        return r;
    endfunction

    // Push n golden vectors back to back; the matching output follows lat cycles later
    task automatic run_stream(input int n, input int lat, input int b1, input int m1,
                              input int b2, input int m2);
        logic [DW-1:0] v;
        for (int c = 0; c < n + lat; c++) begin
            exp_valid = (c < n);
            exp_llr   = (c < n) ? gold(c) : '0;
            if (c >= lat) begin
                v = gold(c - lat);
                if (c - lat == b1) v = corrupt(v, m1);
                if (c - lat == b2) v = corrupt(v, m2);
                dut_valid = 1'b1;
                dut_llr   = v;
            end else begin
                dut_valid = 1'b0;
            end
            step();
        end
        exp_valid = 1'b0;
        dut_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1, 100, 9,  -1, 0,         -1, 0,         100, 100, 0, 0,  0};
        tbl[1] = '{3, 50,  5,  7,  6'b001001, -1, 0,         50,  49,  1, 7,  6'b001000};
        tbl[2] = '{2, 20,  1,  0,  6'b100000, -1, 0,         20,  19,  1, 0,  6'b100000};
        tbl[3] = '{5, 30,  16, 29, 6'b000001, -1, 0,         30,  29,  1, 29, 6'b000001};
        tbl[4] = '{4, 10,  3,  4,  6'b000001, -1, 0,         10,  10,  0, 0,  0};
        tbl[5] = '{4, 10,  3,  2,  6'b010000, 5,  6'b000010, 10,  8,   1, 2,  6'b010000};

        rst_n = 1'b0; Mode = 3'd0; exp_valid = 1'b0; exp_llr = '0;
        dut_valid = 1'b0; dut_llr = '0; clr = 1'b0; rd_mode = 3'd0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_busy", busy, 0);
        check("reset_rd_test", rd_test_cnt, 0);
        check("reset_err_valid", first_err_valid, 0);
        check("reset_flags", {overflow, underflow, mode_err, match, mismatch}, 0);

        for (int t = 0; t < 6; t++) begin
            rd_mode = 3'(tbl[t].mode);
            clr = 1'b1; step(); clr = 1'b0;
            n_match = 0; n_mism = 0;
            Mode = 3'(tbl[t].mode);
            step();
            run_stream(tbl[t].nvec, tbl[t].lat, tbl[t].b1, tbl[t].m1, tbl[t].b2, tbl[t].m2);
            Mode = 3'd0;
            repeat (3) step();
            $display("vec %0d: mode=%0d n=%0d lat=%0d test=%0d pass=%0d err=%0d idx=%0d lanes=%b",
                     t, tbl[t].mode, tbl[t].nvec, tbl[t].lat, rd_test_cnt, rd_pass_cnt,
                     first_err_valid, first_err_idx, first_err_lanes);
            check("tbl_test_cnt", rd_test_cnt, tbl[t].etest);
            check("tbl_pass_cnt", rd_pass_cnt, tbl[t].epass);
            check("tbl_err_valid", first_err_valid, tbl[t].eerr);
            check("tbl_err_mode", first_err_mode, tbl[t].eerr != 0 ? tbl[t].mode : 0);
            check("tbl_err_idx", first_err_idx, tbl[t].eidx);
            check("tbl_err_lanes", first_err_lanes, tbl[t].elanes);
            check("tbl_match_pulses", n_match, tbl[t].epass);
            check("tbl_mismatch_pulses", n_mism, tbl[t].etest - tbl[t].epass);
            check("tbl_overflow", overflow, 0);
            check("tbl_underflow", underflow, 0);
            check("tbl_mode_err", mode_err, 0);
            check("tbl_busy", busy, 0);
        end

        // Overflow: 16 pushes fill the FIFO, the 17th is dropped, then push+pop while full
        rd_mode = 3'd5;
        clr = 1'b1; step(); clr = 1'b0;
        Mode = 3'd5; step();
        for (int i = 0; i < DEPTH; i++) begin
            exp_valid = 1'b1; exp_llr = gold(i); step();
        end
        check("ovf_before", overflow, 0);
        exp_llr = gold(16); step();
        check("ovf_after", overflow, 1);
        exp_llr = gold(17); dut_valid = 1'b1; dut_llr = gold(0); step();
        exp_valid = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            dut_llr = gold(k); step();
        end
        dut_llr = gold(17); step();
        dut_valid = 1'b0; step();
        check("ovf_no_underflow_at_16", underflow, 0);
        dut_valid = 1'b1; step();
        dut_valid = 1'b0; repeat (3) step();
        $display("ovf: test=%0d pass=%0d ovf=%0d unf=%0d", rd_test_cnt, rd_pass_cnt, overflow, underflow);
        check("ovf_underflow_at_17", underflow, 1);
        check("ovf_test_cnt", rd_test_cnt, 17);
        check("ovf_pass_cnt", rd_pass_cnt, 17);
        Mode = 3'd0; step();

        // Drain: Mode drops to 0 with ten outputs still pending
        rd_mode = 3'd2;
        clr = 1'b1; step(); clr = 1'b0;
        Mode = 3'd2; step();
        for (int i = 0; i < 10; i++) begin
            exp_valid = 1'b1; exp_llr = gold(i); step();
        end
        exp_valid = 1'b0; Mode = 3'd0; step();
        check("drain_busy_start", busy, 1);
        for (int i = 0; i < 10; i++) begin
            dut_valid = 1'b1; dut_llr = gold(i); step();
            check("drain_busy", busy, (i < 9) ? 1 : 0);
        end
        dut_valid = 1'b0; repeat (3) step();
        $display("drain: test=%0d pass=%0d busy=%0d", rd_test_cnt, rd_pass_cnt, busy);
        check("drain_test_cnt", rd_test_cnt, 10);
        check("drain_pass_cnt", rd_pass_cnt, 10);

        // Underflow, then a direct 1 -> 4 mode change that must flush the FIFO
        rd_mode = 3'd1;
        clr = 1'b1; step(); clr = 1'b0;
        Mode = 3'd1; step();
        dut_valid = 1'b1; step();
        dut_valid = 1'b0; repeat (3) step();
        check("unf_flag", underflow, 1);
        check("unf_test_cnt", rd_test_cnt, 0);
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_valid = 1'b1; exp_llr = gold(i); step();
        end
        exp_valid = 1'b0; Mode = 3'd4; step();
        check("moderr_flag", mode_err, 1);
        check("moderr_unf_clear", underflow, 0);
        check("moderr_busy", busy, 1);
        dut_valid = 1'b1; dut_llr = gold(0); step();
        dut_valid = 1'b0; rd_mode = 3'd4; repeat (3) step();
        $display("moderr: mode_err=%0d unf=%0d test4=%0d", mode_err, underflow, rd_test_cnt);
        check("flush_underflow", underflow, 1);
        check("flush_test_cnt4", rd_test_cnt, 0);
        check("flush_err_valid", first_err_valid, 0);
        Mode = 3'd0; step();

        // Saturation at 2^CNT_W-1, then a mismatch, then reset mid-run
        rd_mode = 3'd1;
        clr = 1'b1; step(); clr = 1'b0;
        Mode = 3'd1; step();
        run_stream(260, 1, -1, 0, -1, 0);
        repeat (3) step();
        $display("sat: test=%0d pass=%0d", rd_test_cnt, rd_pass_cnt);
        check("sat_test_cnt", rd_test_cnt, 255);
        check("sat_pass_cnt", rd_pass_cnt, 255);
        run_stream(2, 1, 0, 6'b100000, -1, 0);
        repeat (3) step();
        check("sat_test_hold", rd_test_cnt, 255);
        check("sat_err_idx", first_err_idx, 255);
        check("sat_err_lanes", first_err_lanes, 6'b100000);
        for (int i = 0; i < 3; i++) begin
            exp_valid = 1'b1; exp_llr = gold(i); step();
        end
        check("pre_rst_busy", busy, 1);
        check("pre_rst_err_valid", first_err_valid, 1);
        rst_n = 1'b0; dut_valid = 1'b1; dut_llr = gold(0); step();
        $display("midrst: busy=%0d test=%0d err=%0d", busy, rd_test_cnt, first_err_valid);
        check("rst_busy", busy, 0);
        check("rst_rd_cnts", {rd_test_cnt, rd_pass_cnt}, 0);
        check("rst_err", {first_err_valid, first_err_mode, first_err_idx, first_err_lanes}, 0);
        check("rst_flags", {overflow, underflow, mode_err, match, mismatch}, 0);
        rst_n = 1'b1; exp_valid = 1'b0; dut_valid = 1'b0; Mode = 3'd0;
        repeat (3) step();
        check("post_rst_test_cnt", rd_test_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/llr_stream_checker.md
Name: llr_stream_checker

Overview:
- Synthesizable, parametrised self-check block for the multi-mode APSK LLR demapper.
- Buffers golden LLR vectors, which are pushed alongside demapper inputs, in a FIFO. Compares each buffered vector against the next valid demapper output, masking lanes by mode.
- Keeps per-mode tested/passed counters and captures the first mismatch.
- Replaces fixed-latency index alignment with valid-qualified alignment, so it tolerates any pipeline latency up to DEPTH.

Parameters:
- LLR_W, 19, width of one LLR lane
- LANES, 6, LLR lanes per symbol (max bits/symbol)
- DEPTH, 16, expected-vector FIFO depth (power of 2)
- CNT_W, 16, width of per-mode counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- Mode  in  3  0 = idle, 1 = QPSK, 2 = 8PSK, 3 = 16-APSK, 4 = 32-APSK, 5 = 64-APSK; 6/7 treated as 0
- exp_valid  in  1  push golden vector
- exp_llr  in  LANES*LLR_W  golden LLRs, lane 0 in MSBs
- dut_valid  in  1  demapper output valid
- dut_llr  in  LANES*LLR_W  demapper LLRs, lane 0 in MSBs
- clr  in  1  clear counters, first-error capture and sticky flags
- rd_mode  in  3  counter readback select (1..5)
- rd_test_cnt  out  CNT_W  vectors compared for rd_mode (registered)
- rd_pass_cnt  out  CNT_W  vectors fully matching for rd_mode (registered)
- match  out  1  one-cycle pulse: last compare passed
- mismatch  out  1  one-cycle pulse: last compare failed
- first_err_valid  out  1  sticky: a mismatch has been captured
- first_err_mode  out  3  mode of first mismatch
- first_err_idx  out  CNT_W  test count of that mode at mismatch (0-based)
- first_err_lanes  out  LANES  per-lane mismatch mask of first mismatch
- overflow  out  1  sticky: push while full without pop
- underflow  out  1  sticky: dut_valid while FIFO empty
- mode_err  out  1  sticky: non-zero Mode switched to a different non-zero Mode
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n == 0 at posedge): all outputs 0, FIFO empty, counters 0, state IDLE. The same applies mid-run; in-flight entries are discarded.
- FIFO entry = {mode, exp_llr}. The mode is latched at push time, so every compare is attributed to the push-time mode.
- Push only in RUN when exp_valid = 1. exp_valid is ignored in IDLE/DRAIN.
- Pop only on dut_valid, in RUN or DRAIN.
- FSM states:
  - IDLE: enter RUN when Mode is in 1..5.
  - RUN: if Mode becomes 0 (or 6/7), go to DRAIN when FIFO non-empty, else IDLE. If Mode changes to a different value in 1..5, set mode_err, flush FIFO, stay RUN.
  - DRAIN: keep popping/comparing. Go IDLE when FIFO becomes empty. If Mode becomes non-zero, finish draining first, then re-enter RUN the following cycle.
- Active lanes per mode: 1→lanes 0-1, 2→0-2, 3→0-3, 4→0-4, 5→0-5. Inactive lanes are never compared.
- Compare rule: bit-exact equality per active lane; pass = all active lanes equal.
- Latency: dut_valid at posedge t → match/mismatch pulse and counter update visible after posedge t+1.
- Counters: test_cnt[m] +1 per compare; pass_cnt[m] +1 per pass. Both saturate at 2^CNT_W-1 with no wrap.
- rd_test_cnt/rd_pass_cnt register the selected counters each cycle. rd_mode 0/6/7 reads 0.
- First error: on the first mismatch while first_err_valid == 0, capture mode, pre-increment test_cnt of that mode, and the lane mask. Later mismatches are ignored.
- Full + push + pop in the same cycle: both occur, count unchanged, no overflow. Full + push without pop: entry dropped, overflow = 1.
- Empty + dut_valid: no compare, no count, underflow = 1. A push in the same cycle is not bypassed and is written normally.
- clr: counters, first_err_*, and sticky flags go to 0 next cycle. It does not touch FIFO or FSM. A compare in the same cycle as clr is lost (clr wins).

Test Plan:
- Mode = 1, 100 pushes, matching dut outputs with latency 9 → rd_mode = 1 gives rd_test_cnt = 100, rd_pass_cnt = 100, no sticky flags.
- Mode = 3, 50 vectors, vector 7 lane 2 corrupted and lane 5 corrupted (inactive) → pass_cnt = 49, first_err_valid = 1, first_err_mode = 3, first_err_idx = 7, first_err_lanes = 6'b001000.
- Mode = 5 with DEPTH = 16 pushes and no dut_valid, then a 17th push → overflow = 1, FIFO count 16. Then push + pop while full → count stays 16.
- Mode = 2, 10 pushes, Mode → 0 after push 10 with outputs still pending → busy stays 1 in DRAIN until the 10th dut_valid, then IDLE; test_cnt[2] = 10.
- dut_valid with empty FIFO → underflow = 1, all counters unchanged. Then Mode 1 → 4 directly → mode_err = 1 and FIFO flushed.
- Counter at 2^CNT_W-1 plus another pass → holds value. rst_n = 0 mid-run → all outputs 0 next cycle.
